branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It replaces the fixed predict-not-taken scheme, where a taken branch is always discovered late and flushed. In IF it looks up a direct-mapped branch target buffer (BTB) with saturating counters and supplies the next fetch PC. In EX it receives the resolved branch outcome, updates the table, raises a mispredict/recovery request for the flush logic, and keeps saturating performance counters.

## Interface
Parameters:
- ADDR_W, 32, PC width (bits)
- ENTRIES, 16, BTB entries; power of two, at least 2; IDX_W = log2(ENTRIES)
- CNT_W, 2, saturating counter width; at least 1
- STAT_W, 16, width of the performance counters
- PREDICT, 1, 1 = dynamic prediction; 0 = static not-taken compatibility mode

Ports (reset is synchronous, active-high):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous active-high reset
- if_pc  in  ADDR_W  PC of the instruction being fetched
- pred_taken  out  1  prediction for if_pc (combinational)
- pred_next_pc  out  ADDR_W  predicted next fetch PC (combinational)
- upd_valid  in  1  a branch resolves in EX this cycle
- upd_pc  in  ADDR_W  PC of the resolving branch
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction made for this branch, carried down the pipeline
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipeline
- mispredict  out  1  flush request (combinational)
- recover_pc  out  ADDR_W  correct next PC after a mispredict
- br_count  out  STAT_W  number of resolved branches
- miss_count  out  STAT_W  number of mispredicts

## Operation
- Addressing: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; bits [1:0] are ignored.
- Each entry holds valid, tag, target[ADDR_W] and cnt[CNT_W].
- Lookup:
  - hit = valid[idx] & (tag matches)
  - pred_taken = PREDICT & hit & cnt[CNT_W-1]
  - pred_next_pc = pred_taken ? target : if_pc + 4 (mod 2^ADDR_W)
- Update, at the clock edge when upd_valid=1 and reset=0:
  - Update hit, taken: cnt increments, saturating at all-ones; target <= upd_target.
  - Update hit, not taken: cnt decrements, saturating at 0; target is unchanged.
  - Update miss, taken: allocate (overwriting any existing entry at that idx): valid=1, tag and target written, cnt = 2^(CNT_W-1) (weakly taken).
  - Update miss, not taken: no change.
  - PREDICT=0: the table is never written.
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
- recover_pc = upd_taken ? upd_target : upd_pc + 4. This output is valid only while mispredict=1.
- Statistics:
  - br_count increments on every upd_valid.
  - miss_count increments on every mispredict.
  - Both saturate at 2^STAT_W-1 and never wrap.

## Timing
- Lookup latency is 0 cycles (combinational from if_pc). An update becomes visible to lookups from the cycle after its edge.
- Lookup and update in the same cycle, same idx: the lookup returns the pre-update contents. There is no bypass.
- mispredict and recover_pc are combinational in the upd cycle. The pipeline's flush logic consumes them in the same cycle.
- Reset behaviour:
  - Clears every valid bit and cnt, plus br_count and miss_count.
  - Tag and target storage are not reset.
  - After reset: pred_taken=0, pred_next_pc=if_pc+4, br_count=miss_count=0.
  - upd_valid is ignored in any cycle where reset=1, including when reset is asserted mid-stream.
- Counter edges: cnt never wraps; a 1-bit cnt toggles between 0 and 1.

## Test plan
- Reset, then lookup 0x40 -> pred_taken=0, pred_next_pc=0x44, br_count=0, miss_count=0.
- First taken branch at pc 0x40 to 0x100 with upd_pred_taken=0 -> mispredict=1 and recover_pc=0x100 that cycle; next cycle, lookup 0x40 gives pred_taken=1 and pred_next_pc=0x100; miss_count=1.
- With CNT_W=2: allocate 0x40, then resolve not-taken twice -> cnt goes 2→1→0 and pred_taken=0; then taken three times -> cnt reaches 3 and stays at 3.
- Aliasing, ENTRIES=16: 0x40 and 0x80 share idx 0 with different tags. Allocate 0x40 taken, then allocate 0x80 taken -> lookup 0x40 misses (pred_next_pc=0x44), lookup 0x80 hits.
- Lookup and update of 0x40 in the same cycle -> that cycle's lookup shows the old value; the following cycle shows the new value. Assert reset while upd_valid=1 -> table and counters are cleared and the update is discarded.
- PREDICT=0, STAT_W=2: five mispredicting updates -> pred_taken stays 0 and miss_count saturates at 3.

Source files
------------

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the 5-stage MIPS pipeline.
//
// In IF, it looks up a direct-mapped branch target buffer (BTB) and supplies
// the next fetch PC. Each BTB entry holds:
//   - a valid bit
//   - a tag
//   - a taken target
//   - a saturating confidence counter
//
// In EX, the resolved branch outcome does three things:
//   - updates the table
//   - drives the flush request (mispredict / recover_pc)
//   - bumps the saturating performance counters
//
// Parameters:
//   ADDR_W   PC width
//   ENTRIES  BTB entries (power of two, >= 2)
//   CNT_W    confidence counter width (>= 1)
//   STAT_W   performance counter width
//   PREDICT  1 = dynamic prediction, 0 = static not-taken (table never written)
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   if_pc             fetch PC to look up
//   pred_taken        prediction for if_pc (combinational)
//   pred_next_pc      predicted next fetch PC (combinational)
//   upd_valid         a branch resolves in EX this cycle
//   upd_pc            PC of the resolving branch
//   upd_taken         actual outcome
//   upd_target        actual taken target
//   upd_pred_taken    prediction made for this branch
//   upd_pred_target   predicted next PC made for this branch
//   mispredict        flush request (combinational)
//   recover_pc        correct next PC; meaningful only while mispredict = 1
//   br_count          resolved branches (saturating)
//   miss_count        mispredicts (saturating)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16,
    parameter int PREDICT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] recover_pc,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Freshly allocated entries start weakly taken: MSB set, all other bits clear.
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic             PRED_EN  = (PREDICT != 0);

    // -----------------------------------------------------------------------
    // BTB storage.
    // Valid and cnt are reset.
    // Tag and target are plain storage without reset, so they can map onto
    // distributed RAM.
    // -----------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];

    // -----------------------------------------------------------------------
    // Lookup (IF), purely combinational.
    // There is no bypass from a same-cycle update.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [CNT_W-1:0] w_if_cnt;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_cnt = r_cnt[w_if_idx];

    assign pred_taken   = PRED_EN && w_if_hit && w_if_cnt[CNT_W-1];
    assign pred_next_pc = pred_taken ? r_target[w_if_idx] : (if_pc + ADDR_W'(4));

    // -----------------------------------------------------------------------
    // Update (EX)
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_en;

    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_en  = upd_valid && !reset && PRED_EN;

    // Per-entry valid/counter state.
    // Each entry only reacts when the update index selects it.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic w_sel;
            assign w_sel = w_upd_en && (w_upd_idx == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid[gi] <= 1'b0;
                    r_cnt[gi]   <= '0;
                end else if (w_sel) begin
                    if (w_upd_hit) begin
                        // Hit: saturate the counter in the resolved direction.
                        if (upd_taken) begin
                            if (r_cnt[gi] != '1) begin
                                r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                            end
                        end else if (r_cnt[gi] != '0) begin
                            r_cnt[gi] <= r_cnt[gi] - CNT_W'(1);
                        end
                    end else if (upd_taken) begin
                        // Taken miss: allocate, evicting whatever alias lived here.
                        r_valid[gi] <= 1'b1;
                        r_cnt[gi]   <= CNT_WEAK;
                    end
                end
            end
        end
    endgenerate

    // Tag/target write.
    // Both a taken hit and a taken miss write the target. Rewriting the tag
    // on a hit is harmless because it is the same value.
    always_ff @(posedge clk) begin
        if (w_upd_en && upd_taken) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
        end
    end

    // -----------------------------------------------------------------------
    // Flush request
    // -----------------------------------------------------------------------
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign recover_pc = upd_taken ? upd_target : (upd_pc + ADDR_W'(4));

    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            if (upd_valid && (r_br_count != '1)) begin
                r_br_count <= r_br_count + STAT_W'(1);
            end
            if (mispredict && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + STAT_W'(1);
            end
        end
    end

    assign br_count   = r_br_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed, table-driven bench for branch_predictor.
//
// dut:   default parameters (16 entries, 2-bit counters, dynamic prediction).
// dut_s: static mode (PREDICT = 0) with 2-bit statistics counters.
//
// Each table row is one clock cycle:
//   - inputs are driven just after the rising edge
//   - outputs are compared on the falling edge, i.e. before that row's
//     update takes effect
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;

    // Main DUT signals
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic [15:0] br_count;
    logic [15:0] miss_count;

    // Static-mode DUT signals
    logic [31:0] s_if_pc;
    logic        s_pred_taken;
    logic [31:0] s_pred_next_pc;
    logic        s_upd_valid;
    logic        s_mispredict;
    logic [31:0] s_recover_pc;
    logic [1:0]  s_br_count;
    logic [1:0]  s_miss_count;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict     (mispredict),
        .recover_pc     (recover_pc),
        .br_count       (br_count),
        .miss_count     (miss_count)
    );

    // Static mode: every update is a taken branch from 0x40 to 0x100 that
    // was predicted not-taken, so each resolving cycle mispredicts.
    branch_predictor #(.PREDICT(0), .STAT_W(2)) dut_s (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (s_if_pc),
        .pred_taken     (s_pred_taken),
        .pred_next_pc   (s_pred_next_pc),
        .upd_valid      (s_upd_valid),
        .upd_pc         (32'h40),
        .upd_taken      (1'b1),
        .upd_target     (32'h100),
        .upd_pred_taken (1'b0),
        .upd_pred_target(32'h44),
        .mispredict     (s_mispredict),
        .recover_pc     (s_recover_pc),
        .br_count       (s_br_count),
        .miss_count     (s_miss_count)
    );

    typedef struct {
        logic [31:0] ipc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_pt;
        logic [31:0] e_npc;
        logic        e_mp;
        logic [31:0] e_rpc;
        logic [15:0] e_bc;
        logic [15:0] e_mc;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] ipc,  input logic uv, input logic [31:0] upc,
        input logic ut,          input logic [31:0] utgt,
        input logic upt,         input logic [31:0] uptgt,
        input logic e_pt,        input logic [31:0] e_npc,
        input logic e_mp,        input logic [31:0] e_rpc,
        input logic [15:0] e_bc, input logic [15:0] e_mc);
        vec_t v;
        v.ipc = ipc;   v.uv = uv;     v.upc = upc;   v.ut = ut;
        v.utgt = utgt; v.upt = upt;   v.uptgt = uptgt;
        v.e_pt = e_pt; v.e_npc = e_npc; v.e_mp = e_mp; v.e_rpc = e_rpc;
        v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    initial begin
        // Columns:
        //   inputs:   ipc, uv, upc, ut, utgt, upt, uptgt
        //   expected: pt, npc, mp, rpc, bc, mc (pre-edge values)

        // After reset: empty table, counters zero.
        vecs[0]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h0,   0,  0);

        // First taken branch 0x40 -> 0x100.
        // Same-cycle lookup still shows the old (empty) entry.
        vecs[1]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100, 0,  0);
        vecs[2]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0,   1,  1);

        // Not-taken twice: cnt 2 -> 1 -> 0, then a third not-taken holds at 0.
        vecs[3]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  1,  1);
        vecs[4]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h44,  0, 32'h44,  0, 32'h0,   2,  2);
        vecs[5]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h44,  0, 32'h44,  0, 32'h0,   3,  2);

        // Taken four times: cnt 0 -> 1 -> 2 -> 3 -> 3.
        vecs[6]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100, 4,  2);
        vecs[7]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100, 5,  3);
        vecs[8]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0,   6,  4);
        vecs[9]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0,   7,  4);

        // One not-taken from saturated 3 leaves cnt at 2, so still predicted taken.
        vecs[10] = mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  8,  4);
        vecs[11] = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0,   9,  5);

        // Direction correct, target wrong -> mispredict; the new target is learnt.
        vecs[12] = mk(32'h40, 1, 32'h40, 1, 32'h200, 1, 32'h100, 1, 32'h100, 1, 32'h200, 9,  5);
        vecs[13] = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0,   10, 6);

        // Alias: 0x80 takes over idx 0, so 0x40 now misses.
        vecs[14] = mk(32'h80, 1, 32'h80, 1, 32'h300, 0, 32'h84,  0, 32'h84,  1, 32'h300, 10, 6);
        vecs[15] = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h0,   11, 7);
        vecs[16] = mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0,   11, 7);

        // A not-taken miss allocates nothing.
        vecs[17] = mk(32'h44, 1, 32'h44, 0, 32'h0,   0, 32'h48,  0, 32'h48,  0, 32'h0,   11, 7);
        vecs[18] = mk(32'h44, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h48,  0, 32'h0,   12, 7);

        // Low PC bits are ignored by the lookup.
        vecs[19] = mk(32'h82, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0,   12, 7);

        // Fall-through PC wraps modulo 2^32.
        vecs[20] = mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0,   12, 7);

        // Hold both DUTs in reset with all inputs idle.
        reset = 1'b1;
        if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        s_if_pc = 32'h40; s_upd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven main sequence
        for (int i = 0; i < NV; i++) begin
            if_pc           = vecs[i].ipc;
            upd_valid       = vecs[i].uv;
            upd_pc          = vecs[i].upc;
            upd_taken       = vecs[i].ut;
            upd_target      = vecs[i].utgt;
            upd_pred_taken  = vecs[i].upt;
            upd_pred_target = vecs[i].uptgt;
            @(negedge clk);
            check($sformatf("v%0d_pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
            check($sformatf("v%0d_pred_next_pc", i), pred_next_pc, vecs[i].e_npc);
            check($sformatf("v%0d_mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].e_mp});
            if (vecs[i].e_mp) begin
                check($sformatf("v%0d_recover_pc", i), recover_pc, vecs[i].e_rpc);
            end
            check($sformatf("v%0d_br_count", i), {16'b0, br_count}, {16'b0, vecs[i].e_bc});
            check($sformatf("v%0d_miss_count", i), {16'b0, miss_count}, {16'b0, vecs[i].e_mc});
            $display("vec %0d: if_pc=0x%08h pt=%0b npc=0x%08h mp=%0b br=%0d miss=%0d",
                     i, if_pc, pred_taken, pred_next_pc, mispredict, br_count, miss_count);
            @(posedge clk);
            #1;
        end

        // Reset asserted together with a taken update: the update is discarded.
        reset = 1'b1;
        if_pc = 32'h44; upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1;
        upd_target = 32'h500; upd_pred_taken = 1'b0; upd_pred_target = 32'h48;
        @(posedge clk);
        #1;
        reset = 1'b0;
        upd_valid = 1'b0;
        @(negedge clk);
        check("rst_upd_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("rst_upd_next_pc", pred_next_pc, 32'h48);
        check("rst_br_count", {16'b0, br_count}, 32'd0);
        check("rst_miss_count", {16'b0, miss_count}, 32'd0);
        if_pc = 32'h80;
        #1;
        check("rst_alias_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("rst_alias_next_pc", pred_next_pc, 32'h84);
        $display("midstream reset: 0x80 npc=0x%08h br=%0d miss=%0d",
                 pred_next_pc, br_count, miss_count);

        // Static mode: five mispredicting updates.
        // The table stays empty; both stat counters stop at 3.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            s_upd_valid = 1'b1;
            @(negedge clk);
            check($sformatf("s%0d_pred_taken", i), {31'b0, s_pred_taken}, 32'd0);
            check($sformatf("s%0d_mispredict", i), {31'b0, s_mispredict}, 32'd1);
            check($sformatf("s%0d_miss_count", i), {30'b0, s_miss_count}, (i > 3) ? 32'd3 : 32'(i));
            $display("static %0d: pt=%0b mp=%0b br=%0d miss=%0d",
                     i, s_pred_taken, s_mispredict, s_br_count, s_miss_count);
            @(posedge clk);
            #1;
        end
        s_upd_valid = 1'b0;
        @(negedge clk);
        check("s_final_pred_taken", {31'b0, s_pred_taken}, 32'd0);
        check("s_final_next_pc", s_pred_next_pc, 32'h44);
        check("s_final_miss_count", {30'b0, s_miss_count}, 32'd3);
        check("s_final_br_count", {30'b0, s_br_count}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
